cfg_wb_sequencer: RTL

- Autonomous Wishbone master that loads the fabric bitstream into the NUM_CONFIG_REGIONS config regions. It consumes 32-bit column-byte words from a valid/ready stream and issues the count-register and shift-data writes needed to fill every column.
- Sits between a bitstream source (SPI flash reader or host FIFO) and the fabric's Wishbone slave port, replacing software-driven configuration.

---
 rtl/cfg_wb_sequencer.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cfg_wb_sequencer.sv
// Autonomous Wishbone master that streams the fabric bitstream into the config regions.
// Issues count-register arm writes, per-byte data writes, then remainder or flush writes.
module cfg_wb_sequencer #(
    parameter int unsigned NUM_CONFIG_REGIONS = 2,
    parameter int unsigned NUM_COLS           = 7,
    parameter int unsigned COL_BITS           = 1003,
    parameter logic [31:0] BASE_ADDR          = 32'h3000_0000,
    parameter int unsigned GAP_CYCLES         = 5,
    parameter int unsigned ACK_TIMEOUT        = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i
);

    localparam int unsigned NUM_BYTES = COL_BITS / 8;
    localparam int unsigned REM_BITS  = COL_BITS % 8;
    localparam int unsigned BW        = $clog2(NUM_BYTES + 1);
    localparam int unsigned RW        = $clog2(NUM_CONFIG_REGIONS + 1);
    localparam int unsigned TW        = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int unsigned GW        = (GAP_LOAD > 0) ? $clog2(GAP_LOAD + 1) : 1;
    localparam logic [7:0]  REM_CNT_BYTE  = 8'(REM_BITS);
    localparam logic [7:0]  REM_DATA_MASK = 8'((1 << REM_BITS) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_FETCH, S_WRITE, S_DONE, S_ERR
    } state_t;

    typedef enum logic [2:0] {
        PH_ARM, PH_DATA, PH_REMCNT, PH_REMDATA, PH_ZCNT, PH_FLUSH, PH_END
    } phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [RW-1:0] region_q, region_d;
    logic [BW-1:0] byte_q, byte_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] ack_cnt_q, ack_cnt_d;
    logic          cyc_q, cyc_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          s_ready_q, s_ready_d;

    logic [31:0]   lane_mask_c;
    logic [31:0]   cnt_adr_c;
    logic [31:0]   data_adr_c;
    logic [31:0]   wr_adr_c;
    logic [31:0]   wr_dat_c;
    logic          last_region_c;
    logic          last_byte_c;

    // Lanes beyond the last fabric column never carry data.
    always_comb begin
        lane_mask_c = '0;
        for (int j = 0; j < 4; j++) begin
            if ((32'(region_q) * 32'd4 + 32'(j)) < 32'(NUM_COLS)) begin
                lane_mask_c[j*8 +: 8] = 8'hFF;
            end
        end
    end

    // Address and payload of the write belonging to the current phase/region.
    always_comb begin
        cnt_adr_c  = BASE_ADDR + 32'd4 + (32'(region_q) << 4);
        data_adr_c = BASE_ADDR + 32'd8 + (32'(region_q) << 4);
        wr_adr_c   = data_adr_c;
        wr_dat_c   = '0;
        case (phase_q)
            PH_ARM: begin
                wr_adr_c = cnt_adr_c;
                wr_dat_c = 32'hFFFF_FFFF;
            end
            PH_DATA:    wr_dat_c = s_data & lane_mask_c;
            PH_REMCNT: begin
                wr_adr_c = cnt_adr_c;
                wr_dat_c = {4{REM_CNT_BYTE}} & lane_mask_c;
            end
            PH_REMDATA: wr_dat_c = s_data & lane_mask_c & {4{REM_DATA_MASK}};
            PH_ZCNT:    wr_adr_c = cnt_adr_c;
            default:    wr_dat_c = '0;
        endcase
    end

    assign last_region_c = (region_q == RW'(NUM_CONFIG_REGIONS - 1));
    assign last_byte_c   = (byte_q == BW'(NUM_BYTES - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        region_d  = region_q;
        byte_d    = byte_q;
        gap_d     = gap_q;
        ack_cnt_d = ack_cnt_q;
        cyc_d     = cyc_q;
        adr_d     = adr_q;
        dat_d     = dat_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d  = S_GAP;
                    phase_d  = PH_ARM;
                    region_d = '0;
                    byte_d   = '0;
                    gap_d    = '0;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    case (phase_q)
                        PH_DATA, PH_REMDATA: state_d = S_FETCH;
                        PH_END:              state_d = S_DONE;
                        default: begin
                            state_d   = S_WRITE;
                            cyc_d     = 1'b1;
                            adr_d     = wr_adr_c;
                            dat_d     = wr_dat_c;
                            ack_cnt_d = '0;
                        end
                    endcase
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            S_FETCH: begin
                if (s_valid) begin
                    state_d   = S_WRITE;
                    cyc_d     = 1'b1;
                    adr_d     = wr_adr_c;
                    dat_d     = wr_dat_c;
                    ack_cnt_d = '0;
                end
            end
            S_WRITE: begin
                if (wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = S_GAP;
                    gap_d   = (phase_q == PH_ARM) ? '0 : GW'(GAP_LOAD);
                    // Advance the region/byte position; counters wrap on transitions.
                    case (phase_q)
                        PH_ARM: begin
                            region_d = last_region_c ? '0 : region_q + RW'(1);
                            if (last_region_c) begin
                                phase_d = PH_DATA;
                                byte_d  = '0;
                            end
                        end
                        PH_DATA: begin
                            if (last_byte_c) begin
                                byte_d   = '0;
                                region_d = last_region_c ? '0 : region_q + RW'(1);
                                if (last_region_c) begin
                                    phase_d = (REM_BITS > 0) ? PH_REMCNT : PH_ZCNT;
                                end
                            end else begin
                                byte_d = byte_q + BW'(1);
                            end
                        end
                        PH_REMCNT: begin
                            region_d = last_region_c ? '0 : region_q + RW'(1);
                            if (last_region_c) phase_d = PH_REMDATA;
                        end
                        PH_ZCNT: begin
                            region_d = last_region_c ? '0 : region_q + RW'(1);
                            if (last_region_c) phase_d = PH_FLUSH;
                        end
                        default: begin
                            region_d = last_region_c ? '0 : region_q + RW'(1);
                            if (last_region_c) phase_d = PH_END;
                        end
                    endcase
                end else if (ack_cnt_q == TW'(ACK_TIMEOUT - 1)) begin
                    cyc_d   = 1'b0;
                    state_d = S_ERR;
                end else begin
                    ack_cnt_d = ack_cnt_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d    = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
        done_d    = (state_d == S_DONE);
        error_d   = (state_d == S_ERR);
        s_ready_d = (state_d == S_FETCH);
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q   <= S_IDLE;
            phase_q   <= PH_ARM;
            region_q  <= '0;
            byte_q    <= '0;
            gap_q     <= '0;
            ack_cnt_q <= '0;
            cyc_q     <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            region_q  <= region_d;
            byte_q    <= byte_d;
            gap_q     <= gap_d;
            ack_cnt_q <= ack_cnt_d;
            cyc_q     <= cyc_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign s_ready   = s_ready_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = cyc_q;
    assign wbm_sel_o = 4'hF;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule
